// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the PSRAM port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    // Start of the DCJ11 I/O page; never forwarded to PSRAM.
    localparam logic [21:0] IOPAGE_BASE = 22'o17760000;

endpackage

// File: rtl/mem_arbiter_if.sv
// Command/read-return channel between the arbiter and the PSRAM controller.
interface mem_arbiter_if #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 16
);
    // Command transfers on an edge where mem_cmd_valid and mem_cmd_ready are both 1.
    // The master keeps valid high and the payload stable until that edge (only reset
    // may withdraw it). Read data comes back as a single-cycle mem_rdata_valid strobe
    // with no backpressure.
    logic              mem_cmd_valid;
    logic              mem_cmd_ready;
    logic              mem_we;
    logic [1:0]        mem_mask;
    logic [ADDR_W-2:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rdata_valid;

    modport master (
        output mem_cmd_valid, mem_we, mem_mask, mem_addr, mem_wdata,
        input  mem_cmd_ready, mem_rdata, mem_rdata_valid
    );

    modport slave (
        input  mem_cmd_valid, mem_we, mem_mask, mem_addr, mem_wdata,
        output mem_cmd_ready, mem_rdata, mem_rdata_valid
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (DCJ11 CPU, host loader) in front of the single PSRAM port,
// with I/O-page reject, read timeout and host anti-starvation.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int ADDR_W     = 22,
    parameter  int DATA_W     = 16,
    parameter  int STARVE_LIM = 8,
    parameter  int RD_TIMEOUT = 64,
    localparam int SC_W       = $clog2(STARVE_LIM + 1),
    localparam int TO_W       = $clog2(RD_TIMEOUT + 1)
) (
    input  logic              clk_x2,
    input  logic              rstb,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_byte,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_err,

    input  logic              host_req,
    input  logic              host_we,
    input  logic              host_byte,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ack,
    output logic              host_err,

    mem_arbiter_if.master     mem,

    output logic              owner,
    output logic              busy,
    output arb_state_t        dbg_state,
    output logic [SC_W-1:0]   dbg_starve_cnt
);

    arb_state_t        state_q, state_d;
    owner_t            owner_q;
    logic              rearm_q;
    logic [SC_W-1:0]   starve_cnt;
    logic [TO_W-1:0]   tmo_cnt;
    logic              cmd_we;
    logic [1:0]        cmd_mask;
    logic [ADDR_W-2:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              grant_any, grant_host;
    logic              sel_we, sel_byte, sel_reject;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [1:0]        sel_mask;
    logic              tmo_hit;

    // The cycle after DONE makes no grant at all, so a requester that still holds
    // req while reacting to its ack cannot be granted a second time.
    always_comb begin
        grant_any  = (state_q == IDLE) && !rearm_q && (cpu_req || host_req);
        grant_host = host_req && (!cpu_req || starve_cnt == SC_W'(STARVE_LIM));
        sel_we     = grant_host ? host_we    : cpu_we;
        sel_byte   = grant_host ? host_byte  : cpu_byte;
        sel_addr   = grant_host ? host_addr  : cpu_addr;
        sel_wdata  = grant_host ? host_wdata : cpu_wdata;
        sel_reject = sel_addr >= ADDR_W'(IOPAGE_BASE);
        sel_mask   = 2'b11;
        if (sel_we && sel_byte) begin
            sel_mask = sel_addr[0] ? 2'b10 : 2'b01;
        end
        tmo_hit = (tmo_cnt == TO_W'(RD_TIMEOUT - 1));
    end

    always_ff @(posedge clk_x2) begin
        if (!rstb) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_any) state_d = sel_reject ? DONE : ISSUE;
            ISSUE:   if (mem.mem_cmd_ready) state_d = cmd_we ? DONE : WAIT_RD;
            WAIT_RD: if (mem.mem_rdata_valid || tmo_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_x2) begin
        if (!rstb) begin
            owner_q    <= OWN_CPU;
            rearm_q    <= 1'b0;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            cmd_we     <= 1'b0;
            cmd_mask   <= 2'b00;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            rearm_q <= (state_q == DONE);
            if (grant_any) begin
                owner_q   <= grant_host ? OWN_HOST : OWN_CPU;
                cmd_we    <= sel_we;
                cmd_mask  <= sel_mask;
                cmd_addr  <= sel_addr[ADDR_W-1:1];
                cmd_wdata <= sel_wdata;
                rsp_rdata <= '0;
                rsp_err   <= sel_reject;
                tmo_cnt   <= '0;
                if (grant_host || !host_req) begin
                    starve_cnt <= '0;
                end else if (starve_cnt != SC_W'(STARVE_LIM)) begin
                    starve_cnt <= starve_cnt + SC_W'(1);
                end
            end
            if (state_q == WAIT_RD) begin
                if (mem.mem_rdata_valid) begin
                    rsp_rdata <= mem.mem_rdata;
                    rsp_err   <= 1'b0;
                end else if (tmo_hit) begin
                    rsp_err <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + TO_W'(1);
                end
            end
        end
    end

    always_comb begin
        mem.mem_cmd_valid = (state_q == ISSUE);
        mem.mem_we        = (state_q == ISSUE) && cmd_we;
        mem.mem_mask      = (state_q == ISSUE) ? cmd_mask : 2'b00;
        mem.mem_addr      = cmd_addr;
        mem.mem_wdata     = cmd_wdata;

        cpu_ack    = (state_q == DONE) && (owner_q == OWN_CPU);
        host_ack   = (state_q == DONE) && (owner_q == OWN_HOST);
        cpu_err    = cpu_ack && rsp_err;
        host_err   = host_ack && rsp_err;
        cpu_rdata  = cpu_ack ? rsp_rdata : '0;
        host_rdata = host_ack ? rsp_rdata : '0;

        owner          = owner_q;
        busy           = (state_q != IDLE);
        dbg_state      = state_q;
        dbg_starve_cnt = starve_cnt;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one task per scenario, inline checks.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W     = 22;
  localparam int DATA_W     = 16;
  localparam int STARVE_LIM = 8;
  localparam int RD_TIMEOUT = 64;
  localparam int SC_W       = $clog2(STARVE_LIM + 1);

  logic              clk_x2 = 1'b0;
  logic              rstb   = 1'b0;
  logic              cpu_req, cpu_we, cpu_byte;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              cpu_ack, cpu_err;
  logic              host_req, host_we, host_byte;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata, host_rdata;
  logic              host_ack, host_err;
  logic              owner, busy;
  arb_state_t        dbg_state;
  logic [SC_W-1:0]   dbg_starve_cnt;

  int total = 0;
  int bad   = 0;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

  mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIM(STARVE_LIM), .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .clk_x2(clk_x2), .rstb(rstb),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_byte(cpu_byte), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .host_req(host_req), .host_we(host_we), .host_byte(host_byte), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack), .host_err(host_err),
    .mem(mem_if.master),
    .owner(owner), .busy(busy), .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // clock / reset
  always #5 clk_x2 = ~clk_x2;

  task automatic step();
    @(posedge clk_x2);
    #1;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!mem_if.mem_cmd_valid && n < max) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    step();
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (mem_if.mem_cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", mem_if.mem_cmd_valid); end
    total++; if ({cpu_ack, host_ack, cpu_err, host_err} !== 4'b0) begin bad++; $display("FAIL reset_acks got=%b exp=0000", {cpu_ack, host_ack, cpu_err, host_err}); end
    total++; if ({mem_if.mem_mask, mem_if.mem_we, owner} !== 4'b0) begin bad++; $display("FAIL reset_mask_we_owner got=%b exp=0000", {mem_if.mem_mask, mem_if.mem_we, owner}); end
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
    total++; if (dbg_starve_cnt !== '0) begin bad++; $display("FAIL reset_starve got=%0d exp=0", dbg_starve_cnt); end
    total++; if ({mem_if.mem_addr, mem_if.mem_wdata, cpu_rdata} !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", {mem_if.mem_addr, mem_if.mem_wdata, cpu_rdata}); end
    rstb = 1'b1;
    step();
  endtask

  task automatic test_word_write();
    logic [ADDR_W-2:0] exp_addr;
    exp_addr = 21'o000400;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_byte = 1'b0;
    cpu_addr = 22'o001000; cpu_wdata = 16'o123456;
    mem_if.mem_cmd_ready = 1'b1;
    step(); // cycle 2: ISSUE
    total++; if (mem_if.mem_cmd_valid !== 1'b1) begin bad++; $display("FAIL ww_valid got=%0b exp=1", mem_if.mem_cmd_valid); end
    total++; if (mem_if.mem_addr !== exp_addr) begin bad++; $display("FAIL ww_addr got=%o exp=%o", mem_if.mem_addr, exp_addr); end
    total++; if (mem_if.mem_mask !== 2'b11) begin bad++; $display("FAIL ww_mask got=%b exp=11", mem_if.mem_mask); end
    total++; if ({mem_if.mem_we, mem_if.mem_wdata} !== {1'b1, 16'o123456}) begin bad++; $display("FAIL ww_we_data got=%b/%o exp=1/123456", mem_if.mem_we, mem_if.mem_wdata); end
    total++; if (owner !== 1'b0) begin bad++; $display("FAIL ww_owner got=%0b exp=0", owner); end
    step(); // cycle 3: ack
    total++; if ({cpu_ack, cpu_err, host_ack} !== 3'b100) begin bad++; $display("FAIL ww_ack got=%b exp=100", {cpu_ack, cpu_err, host_ack}); end
    step(); // re-arm cycle, req still held
    total++; if ({cpu_ack, busy} !== 2'b00) begin bad++; $display("FAIL ww_rearm got=%b exp=00", {cpu_ack, busy}); end
    step();
    cpu_req = 1'b0;
    total++; if ({busy, host_ack} !== 2'b00) begin bad++; $display("FAIL ww_no_regrant got=%b exp=00", {busy, host_ack}); end
    step();
  endtask

  task automatic test_byte_then_read();
    int n;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_byte = 1'b1;
    cpu_addr = 22'o001001; cpu_wdata = 16'h5A00;
    mem_if.mem_cmd_ready = 1'b0;
    wait_valid(6, n);
    total++; if (n >= 6) begin bad++; $display("FAIL bw_valid_timeout got=%0d exp<6", n); end
    total++; if (mem_if.mem_mask !== 2'b10) begin bad++; $display("FAIL bw_mask got=%b exp=10", mem_if.mem_mask); end
    step();
    step();
    total++; if ({mem_if.mem_cmd_valid, mem_if.mem_mask, mem_if.mem_we} !== 4'b1101) begin bad++; $display("FAIL bw_stall_hold got=%b exp=1101", {mem_if.mem_cmd_valid, mem_if.mem_mask, mem_if.mem_we}); end
    mem_if.mem_cmd_ready = 1'b1;
    step();
    total++; if (cpu_ack !== 1'b1) begin bad++; $display("FAIL bw_ack got=%0b exp=1", cpu_ack); end
    cpu_req = 1'b0;
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte = 1'b0;
    wait_valid(6, n);
    total++; if ({mem_if.mem_cmd_valid, mem_if.mem_mask, mem_if.mem_we} !== 4'b1110) begin bad++; $display("FAIL rd_cmd got=%b exp=1110", {mem_if.mem_cmd_valid, mem_if.mem_mask, mem_if.mem_we}); end
    for (int k = 0; k < 5; k++) step();
    total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL rd_early_ack got=%0b exp=0", cpu_ack); end
    mem_if.mem_rdata = 16'hA5C3; mem_if.mem_rdata_valid = 1'b1;
    step();
    mem_if.mem_rdata_valid = 1'b0;
    total++; if ({cpu_ack, cpu_err, host_ack} !== 3'b100) begin bad++; $display("FAIL rd_ack got=%b exp=100", {cpu_ack, cpu_err, host_ack}); end
    total++; if (cpu_rdata !== 16'hA5C3) begin bad++; $display("FAIL rd_data got=%h exp=a5c3", cpu_rdata); end
    cpu_req = 1'b0;
    step();
    step();
  endtask

  task automatic test_starvation();
    logic        got_owner[18];
    logic [SC_W-1:0] got_sc[18];
    logic        exp_owner;
    logic [SC_W-1:0] exp_sc;
    int ng = 0;
    int cyc = 0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_byte = 1'b0; cpu_addr = 22'o002000; cpu_wdata = 16'h1111;
    host_req = 1'b1; host_we = 1'b1; host_byte = 1'b0; host_addr = 22'o003000; host_wdata = 16'h2222;
    mem_if.mem_cmd_ready = 1'b1;
    while (ng < 18 && cyc < 300) begin
      step();
      cyc++;
      if (mem_if.mem_cmd_valid) begin
        got_owner[ng] = owner;
        got_sc[ng]    = dbg_starve_cnt;
        ng++;
      end
    end
    total++; if (ng != 18) begin bad++; $display("FAIL starve_grant_count got=%0d exp=18", ng); end
    for (int i = 0; i < ng; i++) begin
      exp_owner = (i % 9 == 8);
      exp_sc    = (i % 9 == 8) ? SC_W'(0) : SC_W'(i % 9 + 1);
      total++; if (got_owner[i] !== exp_owner) begin bad++; $display("FAIL starve_owner[%0d] got=%0b exp=%0b", i, got_owner[i], exp_owner); end
      total++; if (got_sc[i] !== exp_sc) begin bad++; $display("FAIL starve_cnt[%0d] got=%0d exp=%0d", i, got_sc[i], exp_sc); end
    end
    cpu_req = 1'b0; host_req = 1'b0;
    for (int k = 0; k < 5; k++) step();
  endtask

  task automatic test_iopage_reject();
    int saw_valid = 0;
    host_req = 1'b1; host_we = 1'b0; host_byte = 1'b0; host_addr = 22'o17777560;
    step();
    if (mem_if.mem_cmd_valid) saw_valid++;
    total++; if ({host_ack, host_err, cpu_ack, owner} !== 4'b1101) begin bad++; $display("FAIL rej_host_ack got=%b exp=1101", {host_ack, host_err, cpu_ack, owner}); end
    total++; if (host_rdata !== 16'h0) begin bad++; $display("FAIL rej_host_rdata got=%h exp=0", host_rdata); end
    host_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      if (mem_if.mem_cmd_valid) saw_valid++;
    end
    total++; if (saw_valid != 0) begin bad++; $display("FAIL rej_no_cmd got=%0d exp=0", saw_valid); end
    // exactly at the I/O page base: rejected
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_byte = 1'b0; cpu_addr = 22'o17760000; cpu_wdata = 16'h3333;
    step();
    total++; if ({cpu_ack, cpu_err, mem_if.mem_cmd_valid} !== 3'b110) begin bad++; $display("FAIL rej_base got=%b exp=110", {cpu_ack, cpu_err, mem_if.mem_cmd_valid}); end
    cpu_req = 1'b0;
    step();
    step();
    // last word below the I/O page: forwarded
    cpu_req = 1'b1; cpu_addr = 22'o17757776;
    step();
    total++; if ({mem_if.mem_cmd_valid, mem_if.mem_addr} !== {1'b1, 21'o7767777}) begin bad++; $display("FAIL below_base_cmd got=%b/%o exp=1/7767777", mem_if.mem_cmd_valid, mem_if.mem_addr); end
    step();
    total++; if ({cpu_ack, cpu_err} !== 2'b10) begin bad++; $display("FAIL below_base_ack got=%b exp=10", {cpu_ack, cpu_err}); end
    cpu_req = 1'b0;
    step();
    step();
  endtask

  task automatic test_read_timeout();
    int n;
    int acks = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = 22'o000100;
    mem_if.mem_cmd_ready = 1'b1;
    wait_valid(6, n);
    step();
    total++; if (dbg_state !== WAIT_RD) begin bad++; $display("FAIL to_enter got=%0d exp=%0d", dbg_state, WAIT_RD); end
    n = 0;
    while (!cpu_ack && n < 100) begin
      step();
      n++;
    end
    total++; if (n != 64) begin bad++; $display("FAIL to_latency got=%0d exp=64", n); end
    total++; if ({cpu_ack, cpu_err, cpu_rdata} !== {2'b11, 16'h0}) begin bad++; $display("FAIL to_err got=%b/%b/%h exp=1/1/0", cpu_ack, cpu_err, cpu_rdata); end
    cpu_req = 1'b0;
    step();
    mem_if.mem_rdata = 16'h1234; mem_if.mem_rdata_valid = 1'b1;
    step();
    mem_if.mem_rdata_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (cpu_ack || host_ack || busy) acks++;
      step();
    end
    total++; if (acks != 0) begin bad++; $display("FAIL to_late_valid got=%0d exp=0", acks); end
  endtask

  task automatic test_reset_midop();
    int n;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = 22'o000200;
    mem_if.mem_cmd_ready = 1'b1;
    wait_valid(6, n);
    for (int k = 0; k < 4; k++) step();
    rstb = 1'b0;
    cpu_req = 1'b0;
    step();
    total++; if ({busy, mem_if.mem_cmd_valid, cpu_ack} !== 3'b000) begin bad++; $display("FAIL mid_reset got=%b exp=000", {busy, mem_if.mem_cmd_valid, cpu_ack}); end
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL mid_reset_state got=%0d exp=%0d", dbg_state, IDLE); end
    step();
    rstb = 1'b1;
    step();
    total++; if ({cpu_ack, busy} !== 2'b00) begin bad++; $display("FAIL mid_reset_no_ack got=%b exp=00", {cpu_ack, busy}); end
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 22'o004000; cpu_wdata = 16'hBEEF;
    n = 0;
    while (!cpu_ack && n < 10) begin
      step();
      n++;
    end
    total++; if (n != 2) begin bad++; $display("FAIL mid_reset_fresh_latency got=%0d exp=2", n); end
    total++; if (cpu_err !== 1'b0) begin bad++; $display("FAIL mid_reset_fresh_err got=%0b exp=0", cpu_err); end
    cpu_req = 1'b0;
    step();
    step();
  endtask

  initial begin
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_byte = 1'b0; host_addr = '0; host_wdata = '0;
    mem_if.mem_cmd_ready = 1'b0; mem_if.mem_rdata = '0; mem_if.mem_rdata_valid = 1'b0;
    test_reset();
    test_word_write();
    test_byte_then_read();
    test_starvation();
    test_iopage_reject();
    test_read_timeout();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
